// File: rtl/config_frame_tx_pkg.sv
// Shared configuration-frame definitions.
// This package holds the frame geometry, the header tag, the transmit FSM
// state encodings and the header byte formatter. The intake side uses the
// same style of definitions.
package config_frame_tx_pkg;

  // Tag carried in header byte 0, bits [7:5].
  localparam logic [2:0] HANDSHAKE       = 3'b110;
  localparam int         NUM_CH          = 8;
  localparam int         DEPTH           = 32;
  localparam int         FRAME_HDR_BYTES = 6;

  localparam int CH_W      = 3;
  localparam int ADDR_W    = 5;
  localparam int HDR_IDX_W = 3;

  typedef enum logic [2:0] {
    CFT_IDLE  = 3'd0,
    CFT_HDR   = 3'd1,
    CFT_FETCH = 3'd2,
    CFT_CAPT  = 3'd3,
    CFT_SEND  = 3'd4,
    CFT_DONE  = 3'd5
  } cft_state_e;

  // Header byte idx (0..5) of the frame built from the snapshot fields.
  function automatic logic [7:0] header_byte(
    input logic [HDR_IDX_W-1:0] idx,
    input logic [7:0]           cs,
    input logic [4:0]           as,
    input logic [31:0]          ps
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = {HANDSHAKE, cs[7:3]};
      3'd1:    b = {cs[2:0], as};
      3'd2:    b = ps[31:24];
      3'd3:    b = ps[23:16];
      3'd4:    b = ps[15:8];
      default: b = ps[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/config_frame_tx_if.sv
// Bus bundle for config_frame_tx.
// Groups the frame request/snapshot inputs, the table-memory read port,
// the UART TX byte handshake and the busy/done status.
//   master : the frame transmitter (drives table reads, tx byte, status)
//   slave  : the surrounding system (drives request, table data, tx_ready)
interface config_frame_tx_if;
  import config_frame_tx_pkg::*;

  logic              start;
  logic [7:0]        channel_select;
  logic [4:0]        aline_select;
  logic [31:0]       pulse_shape;

  logic              tbl_rd_en;
  logic [CH_W-1:0]   tbl_ch;
  logic [ADDR_W-1:0] tbl_addr;
  logic [7:0]        tbl_data;

  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  logic              busy;
  logic              done;

  modport master (
    input  start, channel_select, aline_select, pulse_shape, tbl_data, tx_ready,
    output tbl_rd_en, tbl_ch, tbl_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, channel_select, aline_select, pulse_shape, tbl_data, tx_ready,
    input  tbl_rd_en, tbl_ch, tbl_addr, tx_data, tx_valid, busy, done
  );

endinterface

// File: rtl/config_frame_tx_tx_byte_slot.sv
// Output holding register for the UART TX byte stream.
// A load captures din and raises tx_valid; the byte then stays put until
// the consumer takes it (tx_valid & tx_ready), after which tx_valid drops
// unless a new byte is loaded on the same cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears data and valid)
//   load, din : place a new byte in the slot
//   tx_ready  : consumer accepts the byte held in the slot
//   tx_data, tx_valid : slot contents toward the UART TX core
module tx_byte_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  // The owner only loads when the slot is empty or being emptied this
  // cycle, so a held byte is never overwritten under backpressure.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;

endmodule

// File: rtl/config_frame_tx.sv
// Configuration frame transmitter.
// Serialises one configuration frame (6 header bytes followed by the
// 8-channel x 32-byte delay table) into a byte stream for the UART TX core.
// The table is read from a synchronous memory: one strobe, data one cycle
// later, so each table byte costs FETCH/CAPT/SEND = 3 cycles at full rate.
// Ports:
//   clk, rst : clock, synchronous active-high reset (aborts any frame)
//   bus      : config_frame_tx_if.master
//              start/channel_select/aline_select/pulse_shape - frame request
//              tbl_rd_en/tbl_ch/tbl_addr/tbl_data            - table read port
//              tx_data/tx_valid/tx_ready                     - byte handshake
//              busy/done                                     - status
module config_frame_tx
  import config_frame_tx_pkg::*;
(
  input logic              clk,
  input logic              rst,
  config_frame_tx_if.master bus
);

  localparam logic [HDR_IDX_W-1:0] LAST_HDR_IDX = HDR_IDX_W'(FRAME_HDR_BYTES - 1);
  localparam logic [ADDR_W-1:0]    LAST_ADDR    = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]      LAST_CH      = CH_W'(NUM_CH - 1);

  cft_state_e           state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [HDR_IDX_W-1:0] hdr_idx_q, hdr_idx_d;

  // Request snapshot, frozen for the whole frame.
  logic [7:0]           cs_q, cs_d;
  logic [4:0]           as_q, as_d;
  logic [31:0]          ps_q, ps_d;

  logic                 slot_load;
  logic [7:0]           slot_din;
  logic                 tx_hs;

  assign tx_hs = bus.tx_valid && bus.tx_ready;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    hdr_idx_d = hdr_idx_q;
    cs_d      = cs_q;
    as_d      = as_q;
    ps_d      = ps_q;
    slot_load = 1'b0;
    slot_din  = bus.tbl_data;

    case (state_q)
      CFT_IDLE: begin
        if (bus.start) begin
          cs_d      = bus.channel_select;
          as_d      = bus.aline_select;
          ps_d      = bus.pulse_shape;
          hdr_idx_d = '0;
          // B0 comes straight from the inputs being captured on this edge.
          slot_load = 1'b1;
          slot_din  = header_byte('0, bus.channel_select, bus.aline_select,
                                  bus.pulse_shape);
          state_d   = CFT_HDR;
        end
      end

      CFT_HDR: begin
        if (tx_hs) begin
          if (hdr_idx_q != LAST_HDR_IDX) begin
            // Reload on the handshake cycle keeps tx_valid high: 1 byte/cycle.
            hdr_idx_d = hdr_idx_q + 1'b1;
            slot_load = 1'b1;
            slot_din  = header_byte(hdr_idx_q + 1'b1, cs_q, as_q, ps_q);
          end else begin
            ch_d    = '0;
            addr_d  = '0;
            state_d = CFT_FETCH;
          end
        end
      end

      CFT_FETCH: begin
        state_d = CFT_CAPT;
      end

      CFT_CAPT: begin
        slot_load = 1'b1;
        slot_din  = bus.tbl_data;
        state_d   = CFT_SEND;
      end

      CFT_SEND: begin
        if (tx_hs) begin
          // Terminal compares come first, so neither counter ever wraps.
          if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + 1'b1;
            state_d = CFT_FETCH;
          end else if (ch_q != LAST_CH) begin
            addr_d  = '0;
            ch_d    = ch_q + 1'b1;
            state_d = CFT_FETCH;
          end else begin
            state_d = CFT_DONE;
          end
        end
      end

      CFT_DONE: begin
        state_d = CFT_IDLE;
      end

      default: begin
        state_d = CFT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CFT_IDLE;
      ch_q      <= '0;
      addr_q    <= '0;
      hdr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      hdr_idx_q <= hdr_idx_d;
    end
  end

  // Snapshot is pure data: it is only consumed after being loaded by start.
  always_ff @(posedge clk) begin
    cs_q <= cs_d;
    as_q <= as_d;
    ps_q <= ps_d;
  end

  tx_byte_slot u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (slot_load),
    .din      (slot_din),
    .tx_ready (bus.tx_ready),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid)
  );

  // busy stays high through DONE; it falls on the cycle after the done pulse.
  assign bus.busy      = (state_q != CFT_IDLE);
  assign bus.done      = (state_q == CFT_DONE);
  assign bus.tbl_rd_en = (state_q == CFT_FETCH);
  // Address outputs follow the counters, which only move on the way into
  // FETCH, so they hold their last value in every other state.
  assign bus.tbl_ch    = ch_q;
  assign bus.tbl_addr  = addr_q;

endmodule

// File: tb/tb_config_frame_tx.sv
// Directed testbench for config_frame_tx.
module tb_config_frame_tx;
  import config_frame_tx_pkg::*;

  logic clk;
  logic rst;

  config_frame_tx_if bus();

  config_frame_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [7:0] mem [0:NUM_CH-1][0:DEPTH-1];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  int         cyc;
  int         done_cnt;
  int         rd_cnt;
  int         rd_double;
  int         stall_viol;
  int         ready_pct;
  logic       prev_rd;
  logic [2:0] pend_ch;
  logic [4:0] pend_addr;
  logic       prev_stall;
  logic [7:0] prev_data;

  // One clock: sample just after the edge, drive inputs for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    // Table memory returns data only in the cycle right after a strobe.
    if (prev_rd) bus.tbl_data = mem[pend_ch][pend_addr];
    else         bus.tbl_data = 8'hxx;
    if (bus.tbl_rd_en && !prev_rd) rd_cnt++;
    if (bus.tbl_rd_en && prev_rd)  rd_double++;
    prev_rd   = bus.tbl_rd_en;
    pend_ch   = bus.tbl_ch;
    pend_addr = bus.tbl_addr;
    if (bus.done) done_cnt++;
    if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stall_viol++;
    bus.tx_ready = (int'($urandom_range(99)) < ready_pct);
    if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    prev_stall = bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt   = 0;
    rd_cnt     = 0;
    rd_double  = 0;
    stall_viol = 0;
  endtask

  task automatic fill_mem(input int pattern);
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < DEPTH; a++)
        mem[c][a] = (pattern == 0) ? 8'((c << 5) | a) : 8'(((c * 29) + (a * 7)) ^ 8'h5A);
  endtask

  task automatic set_req(input logic [7:0] cs, input logic [4:0] as, input logic [31:0] ps);
    bus.channel_select = cs;
    bus.aline_select   = as;
    bus.pulse_shape    = ps;
    exp_q.delete();
    exp_q.push_back({HANDSHAKE, cs[7:3]});
    exp_q.push_back({cs[2:0], as});
    exp_q.push_back(ps[31:24]);
    exp_q.push_back(ps[23:16]);
    exp_q.push_back(ps[15:8]);
    exp_q.push_back(ps[7:0]);
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < DEPTH; a++)
        exp_q.push_back(mem[c][a]);
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  function automatic int count_bad();
    int n;
    n = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (got_at(i) !== exp_q[i]) n++;
    return n;
  endfunction

  // Issue one start and run until done (or the budget runs out).
  task automatic run_frame(input int budget, input int mid_byte, input bit start_in_done,
                           output bit to, output int lat, output int busy_low);
    int  s;
    bit  fired;
    to = 1'b1; lat = 0; busy_low = 0; fired = 1'b0;
    s = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        to  = 1'b0;
        lat = cyc - s;
        bus.start = start_in_done;
        step();
        bus.start = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_low++;
      if (mid_byte > 0 && !fired && got.size() == mid_byte) begin
        fired = 1'b1;
        bus.start = 1'b1;
        bus.channel_select = 8'h00;
        bus.aline_select   = 5'h00;
        bus.pulse_shape    = 32'h0;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.tbl_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_tbl_rd_en got %b want 0", bus.tbl_rd_en); end
    n_checks++; if (bus.tbl_ch !== 3'd0) begin n_fail++; $display("FAIL reset_tbl_ch got %0d want 0", bus.tbl_ch); end
    n_checks++; if (bus.tbl_addr !== 5'd0) begin n_fail++; $display("FAIL reset_tbl_addr got %0d want 0", bus.tbl_addr); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_frame();
    bit to; int lat; int bl; int bad;
    clear_mon();
    ready_pct = 100;
    fill_mem(0);
    set_req(8'hA5, 5'h0C, 32'hDEADBEEF);
    run_frame(2000, 0, 1'b0, to, lat, bl);
    for (int i = 0; i < 5; i++) step();
    bad = count_bad();
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", to); end
    n_checks++; if (lat != 775) begin n_fail++; $display("FAIL basic_done_latency got %0d want 775", lat); end
    n_checks++; if (bl != 0) begin n_fail++; $display("FAIL basic_busy_drop got %0d want 0", bl); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    n_checks++; if (got.size() != 262) begin n_fail++; $display("FAIL basic_byte_count got %0d want 262", got.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_stream got %0d bad bytes want 0", bad); end
    // {3'b110, 5'b10100} and {3'b101, 5'b01100}
    n_checks++; if (got_at(0) !== 8'hD4) begin n_fail++; $display("FAIL basic_b0 got %h want d4", got_at(0)); end
    n_checks++; if (got_at(1) !== 8'hAC) begin n_fail++; $display("FAIL basic_b1 got %h want ac", got_at(1)); end
    n_checks++; if (got_at(5) !== 8'hEF) begin n_fail++; $display("FAIL basic_b5 got %h want ef", got_at(5)); end
    n_checks++; if (got_at(6) !== 8'h00) begin n_fail++; $display("FAIL basic_ch0_a0 got %h want 00", got_at(6)); end
    n_checks++; if (got_at(38) !== 8'h20) begin n_fail++; $display("FAIL basic_ch1_a0 got %h want 20", got_at(38)); end
    n_checks++; if (got_at(261) !== 8'hFF) begin n_fail++; $display("FAIL basic_last got %h want ff", got_at(261)); end
  endtask

  task automatic test_backpressure();
    bit to; int lat; int bl; int bad;
    clear_mon();
    ready_pct = 30;
    fill_mem(0);
    set_req(8'hA5, 5'h0C, 32'hDEADBEEF);
    run_frame(9000, 0, 1'b0, to, lat, bl);
    ready_pct = 100;
    for (int i = 0; i < 5; i++) step();
    bad = count_bad();
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b want 0", to); end
    n_checks++; if (got.size() != 262) begin n_fail++; $display("FAIL bp_byte_count got %0d want 262", got.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stream got %0d bad bytes want 0", bad); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_hold got %0d violations want 0", stall_viol); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
    n_checks++; if (lat <= 775) begin n_fail++; $display("FAIL bp_latency got %0d want >775", lat); end
  endtask

  task automatic test_start_while_busy();
    bit to; int lat; int bl; int bad;
    clear_mon();
    ready_pct = 100;
    fill_mem(0);
    set_req(8'hA5, 5'h0C, 32'hDEADBEEF);
    run_frame(2000, 3, 1'b1, to, lat, bl);
    for (int i = 0; i < 12; i++) step();
    bad = count_bad();
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL busy_timeout got %b want 0", to); end
    n_checks++; if (got.size() != 262) begin n_fail++; $display("FAIL busy_byte_count got %0d want 262", got.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL busy_snapshot got %0d bad bytes want 0", bad); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_queue got busy=%b want 0", bus.busy); end
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL busy_idle_valid got %b want 0", bus.tx_valid); end
  endtask

  task automatic test_reset_mid_frame();
    bit to; int lat; int bl; int bad; bit found;
    clear_mon();
    ready_pct = 100;
    fill_mem(0);
    set_req(8'hA5, 5'h0C, 32'hDEADBEEF);
    found = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.tbl_rd_en && bus.tbl_ch == 3'd3 && bus.tbl_addr == 5'd10) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reach_ch3_a10 got %b want 1", found); end
    rst = 1'b1;
    step();
    n_checks++;
    if ({bus.tx_valid, bus.tx_data, bus.busy, bus.done, bus.tbl_rd_en, bus.tbl_ch, bus.tbl_addr} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got v=%b d=%h busy=%b done=%b rd=%b ch=%0d addr=%0d want all 0",
               bus.tx_valid, bus.tx_data, bus.busy, bus.done, bus.tbl_rd_en, bus.tbl_ch, bus.tbl_addr);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL mid_no_done got %0d want 0", done_cnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy got %b want 0", bus.busy); end

    clear_mon();
    set_req(8'h3C, 5'h13, 32'h01234567);
    run_frame(2000, 0, 1'b0, to, lat, bl);
    bad = count_bad();
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL mid_new_timeout got %b want 0", to); end
    // {3'b110, 5'b00111} and {3'b100, 5'b10011}
    n_checks++; if (got_at(0) !== 8'hC7) begin n_fail++; $display("FAIL mid_new_b0 got %h want c7", got_at(0)); end
    n_checks++; if (got_at(1) !== 8'h93) begin n_fail++; $display("FAIL mid_new_b1 got %h want 93", got_at(1)); end
    n_checks++; if (got.size() != 262) begin n_fail++; $display("FAIL mid_new_byte_count got %0d want 262", got.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_new_stream got %0d bad bytes want 0", bad); end
    n_checks++; if (lat != 775) begin n_fail++; $display("FAIL mid_new_latency got %0d want 775", lat); end
  endtask

  task automatic test_table_timing();
    bit to; int lat; int bl; int bad;
    clear_mon();
    ready_pct = 60;
    fill_mem(1);
    set_req(8'h5A, 5'h1F, 32'hCAFEF00D);
    run_frame(6000, 0, 1'b0, to, lat, bl);
    ready_pct = 100;
    for (int i = 0; i < 5; i++) step();
    bad = count_bad();
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL tbl_timeout got %b want 0", to); end
    n_checks++; if (rd_cnt != 256) begin n_fail++; $display("FAIL tbl_strobe_count got %0d want 256", rd_cnt); end
    n_checks++; if (rd_double != 0) begin n_fail++; $display("FAIL tbl_strobe_width got %0d long strobes want 0", rd_double); end
    n_checks++; if (got.size() != 262) begin n_fail++; $display("FAIL tbl_byte_count got %0d want 262", got.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL tbl_stream got %0d bad bytes want 0", bad); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL tbl_hold got %0d violations want 0", stall_viol); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    ready_pct  = 100;
    prev_rd    = 1'b0;
    pend_ch    = '0;
    pend_addr  = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
    rst        = 1'b1;
    bus.start          = 1'b0;
    bus.channel_select = '0;
    bus.aline_select   = '0;
    bus.pulse_shape    = '0;
    bus.tbl_data       = 8'hxx;
    bus.tx_ready       = 1'b0;
    clear_mon();

    test_reset();
    test_basic_frame();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    test_table_timing();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
